// File: rtl/mdio_generador_if.sv
// rtl/mdio_generador_if.sv - MDIO generator request/response and serial line bundle
//   mdio_start/t_data    : frame request and frame word (master -> generator)
//   mdio_in              : serial data returned by the peripheral
//   MDC/mdio_out/mdio_oe : management clock, serial data out, output enable
//   rd_data/data_rdy     : last read result and its one-cycle update strobe
//   busy                 : frame in progress
interface mdio_generador_if;
    logic        mdio_start;
    logic [31:0] t_data;
    logic        mdio_in;
    logic        MDC;
    logic        mdio_out;
    logic        mdio_oe;
    logic [15:0] rd_data;
    logic        data_rdy;
    logic        busy;

    modport master (
        output mdio_start, t_data, mdio_in,
        input  MDC, mdio_out, mdio_oe, rd_data, data_rdy, busy
    );

    modport slave (
        input  mdio_start, t_data, mdio_in,
        output MDC, mdio_out, mdio_oe, rd_data, data_rdy, busy
    );
endinterface

// File: rtl/mdio_generador.sv
// rtl/mdio_generador.sv - MDIO frame generator (preamble, TX, RX, one-cycle DONE)
//   clk : system clock, MDC is clk/2 during a frame
//   rst : synchronous active-low reset
//   bus : mdio_generador_if.slave (request, frame word, serial line, read result)
module mdio_generador (
    input  logic               clk,
    input  logic               rst,
    mdio_generador_if.slave    bus
);
    typedef enum logic [4:0] {
        IDLE     = 5'b00001,
        PREAMBLE = 5'b00010,
        TX       = 5'b00100,
        RX       = 5'b01000,
        DONE     = 5'b10000
    } state_t;

    state_t      state_q, state_d;
    // One counter spans the whole 128-cycle frame: bit 0 is the MDC phase,
    // bits [6:1] the bit-period index (0..31 preamble, 32.. frame bits).
    logic [6:0]  cnt_q, cnt_d;
    logic [31:0] frame_q, frame_d;
    // Holds the first 15 data bits; the 16th comes straight from mdio_in
    // on the closing edge when the result is copied to rd_data.
    logic [14:0] shift_q, shift_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        is_read;
    logic [4:0]  tx_idx;

    assign is_read = (frame_q[29:28] == 2'b10);
    // Frame bit k (32..63) transmits frame_q[63-k] == frame_q[~k[4:0]].
    assign tx_idx  = ~cnt_q[5:1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 7'd0;
            frame_q <= 32'd0;
            shift_q <= 15'd0;
            // A reset that aborts a frame must not disturb the last read
            // result; only a reset taken while idle clears it.
            if (state_q == IDLE)
                rd_data_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            frame_q   <= frame_d;
            shift_q   <= shift_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        frame_d   = frame_q;
        shift_d   = shift_q;
        rd_data_d = rd_data_q;
        case (state_q)
            IDLE: begin
                cnt_d = 7'd0;
                if (bus.mdio_start) begin
                    frame_d = bus.t_data;
                    state_d = PREAMBLE;
                end
            end
            PREAMBLE: begin
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == 7'd63)
                    state_d = TX;
            end
            TX: begin
                cnt_d = cnt_q + 7'd1;
                // Read: 14 header bits end at bit period 45; write: all 32 bits.
                if (is_read && cnt_q == 7'd91)
                    state_d = RX;
                else if (!is_read && cnt_q == 7'd127)
                    state_d = DONE;
            end
            RX: begin
                cnt_d = cnt_q + 7'd1;
                // Bit periods 46,47 are turnaround; data occupies 48..63.
                if (cnt_q[0] && cnt_q[6:1] >= 6'd48)
                    shift_d = {shift_q[13:0], bus.mdio_in};
                if (cnt_q == 7'd127) begin
                    state_d   = DONE;
                    rd_data_d = {shift_q, bus.mdio_in};
                end
            end
            DONE: begin
                cnt_d   = 7'd0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = 7'd0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.MDC      = 1'b0;
        bus.mdio_out = 1'b0;
        bus.mdio_oe  = 1'b0;
        bus.busy     = 1'b0;
        bus.data_rdy = 1'b0;
        case (state_q)
            PREAMBLE: begin
                bus.MDC      = cnt_q[0];
                bus.mdio_out = 1'b1;
                bus.mdio_oe  = 1'b1;
                bus.busy     = 1'b1;
            end
            TX: begin
                bus.MDC      = cnt_q[0];
                bus.mdio_out = frame_q[tx_idx];
                bus.mdio_oe  = 1'b1;
                bus.busy     = 1'b1;
            end
            RX: begin
                bus.MDC  = cnt_q[0];
                bus.busy = 1'b1;
            end
            DONE: begin
                bus.data_rdy = is_read;
            end
            default: ;
        endcase
    end

    assign bus.rd_data = rd_data_q;
endmodule

// File: tb/tb_mdio_generador.sv
// tb/tb_mdio_generador.sv - directed self-checking bench for mdio_generador
module tb_mdio_generador;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    mdio_generador_if bus ();

    mdio_generador dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered in the first PREAMBLE cycle; returns in the DONE cycle.
    task automatic run_frame(input string tag, input logic [31:0] frame,
                             input logic [15:0] rxw, input bit inject);
        logic [63:0] exp_bits, got_bits, exp_oe, got_oe;
        logic        prev_out, prev_oe;
        int          errs;
        int          b;
        bit          rd;
        rd       = (frame[29:28] == 2'b10);
        exp_bits = rd ? {32'hFFFF_FFFF, frame[31:18], 18'b0} : {32'hFFFF_FFFF, frame};
        exp_oe   = rd ? 64'hFFFF_FFFF_FFFC_0000 : 64'hFFFF_FFFF_FFFF_FFFF;
        got_bits = '0;
        got_oe   = '0;
        errs     = 0;
        prev_out = 1'b0;
        prev_oe  = 1'b0;
        for (int c = 0; c < 128; c++) begin
            b = c / 2;
            if (c % 2 == 0)
                bus.mdio_in = (b >= 48) ? rxw[63 - b] : 1'b1;
            if (bus.MDC !== c[0]) errs++;
            if (bus.busy !== 1'b1) errs++;
            if (bus.data_rdy !== 1'b0) errs++;
            if (c % 2 == 0) begin
                prev_out = bus.mdio_out;
                prev_oe  = bus.mdio_oe;
            end else begin
                if (bus.mdio_out !== prev_out || bus.mdio_oe !== prev_oe) errs++;
                got_bits[63 - b] = bus.mdio_out;
                got_oe[63 - b]   = bus.mdio_oe;
            end
            if (inject && c == 20) begin
                bus.mdio_start = 1'b1;
                bus.t_data     = 32'h6FFF_FFFF;
            end
            if (inject && c == 21)
                bus.mdio_start = 1'b0;
            step();
        end
        chk({tag, "_bits"}, got_bits, exp_bits);
        chk({tag, "_oe"}, got_oe, exp_oe);
        chk({tag, "_cycle_errs"}, 64'(errs), 64'd0);
        chk({tag, "_done_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_done_mdc"}, 64'(bus.MDC), 64'd0);
        chk({tag, "_done_oe"}, 64'(bus.mdio_oe), 64'd0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst            = 1'b0;
        bus.mdio_start = 1'b1;
        bus.t_data     = 32'h6000_0000;
        bus.mdio_in    = 1'b0;

        // Reset held with a pending request
        step(); step(); step();
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_mdc", 64'(bus.MDC), 64'd0);
        chk("rst_oe", 64'(bus.mdio_oe), 64'd0);
        chk("rst_out", 64'(bus.mdio_out), 64'd0);
        chk("rst_rdy", 64'(bus.data_rdy), 64'd0);
        chk("rst_rd_data", 64'(bus.rd_data), 64'h0000);

        // First frame starts once rst=1 is sampled with the request high
        rst = 1'b1;
        step();
        chk("start_busy", 64'(bus.busy), 64'd1);
        bus.mdio_start = 1'b0;
        run_frame("read1", 32'h6000_0000, 16'hBEEF, 1'b0);
        chk("read1_rdy", 64'(bus.data_rdy), 64'd1);
        chk("read1_rd_data", 64'(bus.rd_data), 64'hBEEF);
        step();
        chk("read1_idle_rdy", 64'(bus.data_rdy), 64'd0);
        chk("read1_idle_busy", 64'(bus.busy), 64'd0);
        chk("read1_idle_rd_data", 64'(bus.rd_data), 64'hBEEF);

        // Write with a rejected request mid-frame and t_data changed after latch
        bus.t_data     = 32'h5006_ABCD;
        bus.mdio_start = 1'b1;
        step();
        bus.mdio_start = 1'b0;
        bus.t_data     = 32'h0000_0000;
        run_frame("write", 32'h5006_ABCD, 16'h0000, 1'b1);
        chk("write_rdy", 64'(bus.data_rdy), 64'd0);
        chk("write_rd_data", 64'(bus.rd_data), 64'hBEEF);
        step();
        chk("write_idle_busy", 64'(bus.busy), 64'd0);
        step();
        chk("write_idle2_busy", 64'(bus.busy), 64'd0);

        // Abort a read at cycle 80
        bus.t_data     = 32'h6000_0000;
        bus.mdio_start = 1'b1;
        step();
        bus.mdio_start = 1'b0;
        bus.mdio_in    = 1'b1;
        for (int c = 0; c < 80; c++) step();
        chk("abort_pre_busy", 64'(bus.busy), 64'd1);
        rst = 1'b0;
        step();
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_mdc", 64'(bus.MDC), 64'd0);
        chk("abort_oe", 64'(bus.mdio_oe), 64'd0);
        chk("abort_out", 64'(bus.mdio_out), 64'd0);
        chk("abort_rdy", 64'(bus.data_rdy), 64'd0);
        chk("abort_rd_data", 64'(bus.rd_data), 64'hBEEF);
        rst = 1'b1;
        step();
        chk("abort_after_rdy", 64'(bus.data_rdy), 64'd0);
        chk("abort_after_rd_data", 64'(bus.rd_data), 64'hBEEF);

        // Back-to-back reads with the request held through DONE
        bus.t_data     = 32'h6000_0000;
        bus.mdio_start = 1'b1;
        step();
        run_frame("b2b_a", 32'h6000_0000, 16'h1357, 1'b0);
        chk("b2b_a_rdy", 64'(bus.data_rdy), 64'd1);
        chk("b2b_a_rd_data", 64'(bus.rd_data), 64'h1357);
        bus.t_data = 32'h6FFC_0000;
        step();
        chk("b2b_gap_busy", 64'(bus.busy), 64'd0);
        chk("b2b_gap_rdy", 64'(bus.data_rdy), 64'd0);
        step();
        bus.mdio_start = 1'b0;
        run_frame("b2b_b", 32'h6FFC_0000, 16'hC0DE, 1'b0);
        chk("b2b_b_rdy", 64'(bus.data_rdy), 64'd1);
        chk("b2b_b_rd_data", 64'(bus.rd_data), 64'hC0DE);
        step();
        chk("b2b_end_rdy", 64'(bus.data_rdy), 64'd0);
        chk("b2b_end_busy", 64'(bus.busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
